// File: rtl/acpi_pkg.sv
// Shared types and defaults for the ACPI result writer.
// Holds the default pixel/address widths, the writer FSM state enum,
// the FIFO entry layout and a saturating counter helper.
package acpi_pkg;

  localparam int ACPI_DATA_WIDTH = 8;
  localparam int ACPI_ADDRESS    = 14;
  localparam int PIX_CNT_WIDTH   = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } acpi_state_t;

  typedef struct packed {
    logic [ACPI_ADDRESS-1:0]    addr;
    logic [ACPI_DATA_WIDTH-1:0] data;
  } acpi_entry_t;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [PIX_CNT_WIDTH-1:0] sat_inc(input logic [PIX_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/acpi_wr_fifo.sv
// Small power-of-two FIFO buffering {addr, data} pixel entries.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// A push on a full FIFO is accepted only when a pop happens in the same
// cycle; otherwise it is rejected and push_ok stays low.
// Besides the head entry it also exposes the entry behind the head so the
// writer can chain writes without a bubble.
module acpi_wr_fifo
  import acpi_pkg::*;
#(
  parameter int WIDTH = ACPI_ADDRESS + ACPI_DATA_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             push_ok,
  output logic             empty,
  output logic             has_next,
  output logic [WIDTH-1:0] head_data,
  output logic [WIDTH-1:0] next_data
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]      wr_ptr_q, wr_ptr_d;
  logic [PW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW:0]      count;
  logic             full;
  logic             pop_ok;
  logic [PW-1:0]    next_idx;

  assign count     = wr_ptr_q - rd_ptr_q;
  assign empty     = (count == '0);
  assign full      = (count == (PW+1)'(DEPTH));
  assign has_next  = (count >= (PW+1)'(2));
  assign pop_ok    = pop && !empty;
  assign push_ok   = push && (!full || pop_ok);
  assign next_idx  = rd_ptr_q[PW-1:0] + PW'(1);
  assign head_data = mem_q[rd_ptr_q[PW-1:0]];
  assign next_data = mem_q[next_idx];

  // Advance pointers and write the storage slot for accepted pushes.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q[PW-1:0]] = push_data;
      wr_ptr_d = wr_ptr_q + (PW+1)'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + (PW+1)'(1);
    end
  end

  // Pointer registers clear on reset; storage contents do not need it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
    mem_q <= mem_d;
  end

endmodule

// File: rtl/acpi_result_writer.sv
// Result writer for the ACPI demosaic core.
// Buffers strobed pixels in acpi_wr_fifo, drains them into the result SRAM
// over a wr_en/wr_ack handshake, counts committed pixels and raises done
// once finish has been seen and the buffer is empty.
// Optional feature: define ACPI_WR_CHECKSUM_EN to add a 16-bit running
// checksum output of all acknowledged write data.
module acpi_result_writer
  import acpi_pkg::*;
#(
  parameter int DATA_WIDTH  = ACPI_DATA_WIDTH,
  parameter int ADDRESS     = ACPI_ADDRESS,
  parameter int FIFO_DEPTH  = 4,
  parameter int PIXEL_COUNT = 8192
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDRESS-1:0]    acpi_addr,
  input  logic                  acpi_valid,
  input  logic [DATA_WIDTH-1:0] acpi_data,
  input  logic                  acpi_finish,
  output logic                  wr_en,
  output logic [ADDRESS-1:0]    wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_ack,
  output logic [14:0]           pix_count,
  output logic                  overflow,
  output logic                  count_err,
  output logic                  done
`ifdef ACPI_WR_CHECKSUM_EN
  ,
  output logic [15:0]           checksum
`endif
);

  localparam int EW = ADDRESS + DATA_WIDTH;
  localparam logic [PIX_CNT_WIDTH-1:0] PIX_TARGET = PIX_CNT_WIDTH'(PIXEL_COUNT);

  acpi_state_t             state_q, state_d;
  logic                    wr_en_q, wr_en_d;
  logic [ADDRESS-1:0]      wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic [PIX_CNT_WIDTH-1:0] pix_count_q, pix_count_d;
  logic                    overflow_q, overflow_d;
  logic                    count_err_q, count_err_d;
  logic                    done_q, done_d;
  logic                    finish_seen_q, finish_seen_d;

  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    fifo_push_ok;
  logic                    fifo_empty;
  logic                    fifo_has_next;
  logic [EW-1:0]           fifo_head;
  logic [EW-1:0]           fifo_next;

  // Pixels arriving after the frame is done are refused; a pop is an
  // acknowledged write, which only happens while a write is outstanding.
  assign fifo_push = acpi_valid && (state_q != DONE);
  assign fifo_pop  = (state_q == WRITE) && wr_ack;

  acpi_wr_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({acpi_addr, acpi_data}),
    .pop       (fifo_pop),
    .push_ok   (fifo_push_ok),
    .empty     (fifo_empty),
    .has_next  (fifo_has_next),
    .head_data (fifo_head),
    .next_data (fifo_next)
  );

  // Writer FSM next state plus counters and sticky flags.
  always_comb begin
    state_d       = state_q;
    wr_en_d       = wr_en_q;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    pix_count_d   = pix_count_q;
    count_err_d   = count_err_q;
    done_d        = done_q;
    finish_seen_d = finish_seen_q | acpi_finish;
    overflow_d    = overflow_q | (acpi_valid & ~fifo_push_ok);

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          wr_en_d                = 1'b1;
          {wr_addr_d, wr_data_d} = fifo_head;
          state_d                = WRITE;
        end else if (finish_seen_q) begin
          state_d     = DONE;
          done_d      = 1'b1;
          count_err_d = (pix_count_q != PIX_TARGET);
        end
      end
      WRITE: begin
        if (wr_ack) begin
          pix_count_d = sat_inc(pix_count_q);
          if (fifo_has_next) begin
            {wr_addr_d, wr_data_d} = fifo_next;
          end else begin
            wr_en_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      DONE: begin
        done_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        wr_en_d = 1'b0;
      end
    endcase
  end

  // Register the FSM and every output; reset abandons any pending write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      pix_count_q   <= '0;
      overflow_q    <= 1'b0;
      count_err_q   <= 1'b0;
      done_q        <= 1'b0;
      finish_seen_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      pix_count_q   <= pix_count_d;
      overflow_q    <= overflow_d;
      count_err_q   <= count_err_d;
      done_q        <= done_d;
      finish_seen_q <= finish_seen_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign pix_count = pix_count_q;
  assign overflow  = overflow_q;
  assign count_err = count_err_q;
  assign done      = done_q;

`ifdef ACPI_WR_CHECKSUM_EN
  logic [15:0] checksum_q, checksum_d;

  // Accumulate data of every acknowledged write; no acks occur in DONE.
  always_comb begin
    checksum_d = checksum_q;
    if (fifo_pop) begin
      checksum_d = checksum_q + 16'(wr_data_q);
    end
  end

  // Checksum register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`endif

endmodule

// File: doc/acpi_result_writer.md
# acpi_result_writer

Downstream stage of the ACPI demosaic core. It accepts interpolated pixels as single-cycle `acpi_valid`/`acpi_addr`/`acpi_data` strobes, which carry no backpressure, and buffers them in a small FIFO. It drains the FIFO into the result SRAM over a write/acknowledge handshake, counts the committed pixels, and raises `done` once the core's `finish` has been seen and every buffered pixel is written.

## Interface
- `DATA_WIDTH`, 8, pixel width
- `ADDRESS`, 14, result-memory address width (128x128 image)
- `FIFO_DEPTH`, 4, buffer entries (power of two)
- `PIXEL_COUNT`, 8192, pixels expected per frame
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, synchronous, active-low
- `acpi_addr`  in  ADDRESS  address of incoming pixel
- `acpi_valid`  in  1  one-cycle pixel strobe
- `acpi_data`  in  DATA_WIDTH  incoming pixel value
- `acpi_finish`  in  1  upstream end-of-frame level/pulse
- `wr_en`  out  1  result-SRAM write request
- `wr_addr`  out  ADDRESS  write address
- `wr_data`  out  DATA_WIDTH  write data
- `wr_ack`  in  1  SRAM accepted current write
- `pix_count`  out  15  acknowledged writes this frame
- `overflow`  out  1  sticky: pixel dropped on full FIFO
- `count_err`  out  1  sticky: `done` with `pix_count != PIXEL_COUNT`
- `done`  out  1  frame fully committed

## Operation
- FIFO entries are {addr, data}. Push happens on `acpi_valid` when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
- A push on a full FIFO with no pop is dropped and sets `overflow`. The FIFO contents are unchanged.
- `finish_seen` is set sticky on any cycle with `acpi_finish` high.
- FSM states:
  - IDLE: if the FIFO is non-empty, load the head entry into `wr_addr`/`wr_data`, assert `wr_en`, and go to WRITE. Else, if `finish_seen`, go to DONE.
  - WRITE: hold `wr_en`/`wr_addr`/`wr_data` stable until `wr_ack` is sampled high. On ack: pop, increment `pix_count`, then:
    - FIFO still has another entry: load the next one with `wr_en` kept high (stay in WRITE).
    - Otherwise: drop `wr_en` and go to IDLE.
  - DONE: `done`=1. Evaluate `count_err`. Ignore further `acpi_valid`, setting `overflow` if any arrives. Stay in DONE until reset.
- `wr_ack` while `wr_en`=0 is ignored.
- `pix_count` saturates at 2^15-1.
- Reset values: `wr_en`=0, `wr_addr`=0, `wr_data`=0, `pix_count`=0, `overflow`=0, `count_err`=0, `done`=0. Also FIFO empty, `finish_seen`=0, state IDLE.
- Reset mid-write abandons the pending write. `wr_en` is low after the reset edge.

## Timing
- Latency:
  - `acpi_valid` at edge t → entry visible at t+1.
  - `wr_en`=1 at t+2 when IDLE with an empty FIFO.
- Throughput: one write per cycle with `wr_ack` tied high.
- Back-to-back writes carry no bubble.
- `done` rises 2 cycles after the last ack (WRITE→IDLE→DONE) when `finish_seen` is already set.
- `finish` arriving with a non-empty FIFO: DONE waits for the FIFO to drain.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `ACPI_WR_CHECKSUM_EN` defined: adds output port `checksum` (16 bits, reset 0).
  - On every acknowledged write it accumulates `checksum <= checksum + wr_data`, wrapping mod 2^16.
  - It freezes in DONE.
- Undefined: the port and the adder are absent. The rest of the behaviour is identical.

## Structure
- Package `acpi_pkg` holds:
  - `DATA_WIDTH`/`ADDRESS` defaults;
  - the state enum typedef (IDLE, WRITE, DONE);
  - typedef `acpi_entry_t` {addr, data}.
- Sub-module `acpi_wr_fifo` covers storage, pointers, full/empty and the simultaneous push/pop rule.
- The top level holds the FSM, counters, flags and checksum.

## Test plan
- Single pixel: `acpi_valid` with addr 259, data 0x5A; `wr_ack` returned 1 cycle after `wr_en`.
  - Expected: `wr_en` at t+2 with `wr_addr`=259, `wr_data`=0x5A; `pix_count`=1.
- Stall: 6 strobes 5 cycles apart, `wr_ack` held low for 30 cycles.
  - Expected: 4 entries buffered; 5th and 6th dropped; `overflow`=1; after ack release exactly 4 writes in order and `pix_count`=4.
- Full FIFO plus pop: full FIFO, push and `wr_ack` in the same cycle.
  - Expected: the push is accepted, no overflow, the FIFO stays full.
- Finish while buffered: 3 pixels pending, pulse `acpi_finish`.
  - Expected: `done` only after the 3rd ack (+2 cycles); `count_err`=1 since 3≠8192.
- Full frame: 8192 strobes with addresses stepping per the ACPI pattern, `wr_ack` tied high, then finish.
  - Expected: `pix_count`=8192, `count_err`=0, `done`=1; with `ACPI_WR_CHECKSUM_EN`, `checksum` equals the reference sum mod 65536.
- Reset mid-write: `rst`=0 while `wr_en`=1.
  - Expected: next edge has `wr_en`=0, `pix_count`=0, FIFO empty; subsequent pixels are handled normally.
